// File: rtl/port_frz_cpl_responder.sv
// port_frz_cpl_responder
// Owns a port while it is frozen or in reset. Memory reads are answered with
// a single-beat completion: a CplD carrying all-ones data when the read is
// short enough, otherwise an Unsupported Request Cpl. Every other request is
// drained and dropped.
// Completion header layout in tx_tdata[255:0]:
//   [31:24] fmt_type, [9:0] length, [47:40] tag, [63:48] req_id,
//   [70:64] lower address, [108:96] byte count, [111:109] status.
// Optional feature: define PORT_FRZ_CPL_STATS_EN to build the rd_cnt and
// wr_drop_cnt statistics counters; without it both ports read constant 0.
module port_frz_cpl_responder #(
    parameter int TDATA_WIDTH    = 512,
    parameter int HDR_FIFO_DEPTH = 4,
    parameter int MAX_CPL_DW     = 8
) (
    input  logic                   clk,
    input  logic                   softreset,
    input  logic                   frz_active,
    input  logic                   rx_tvalid,
    output logic                   rx_tready,
    input  logic                   rx_tlast,
    input  logic [TDATA_WIDTH-1:0] rx_tdata,
    output logic                   tx_tvalid,
    input  logic                   tx_tready,
    output logic                   tx_tlast,
    output logic [TDATA_WIDTH-1:0] tx_tdata,
    output logic [15:0]            rd_cnt,
    output logic [15:0]            wr_drop_cnt
);
    localparam int AW        = $clog2(HDR_FIFO_DEPTH);
    localparam int EW        = 41;  // {req_id, tag, lower address, length_dw}
    localparam int DATA_BITS = TDATA_WIDTH - 256;

    typedef enum logic {RX_IDLE = 1'b0, RX_DRAIN = 1'b1} rx_state_t;
    typedef enum logic {TX_IDLE = 1'b0, TX_SEND  = 1'b1} tx_state_t;

    rx_state_t              r_rx_state, w_rx_state_nxt;
    tx_state_t              r_tx_state, w_tx_state_nxt;
    logic [EW-1:0]          r_mem [HDR_FIFO_DEPTH];
    logic [AW:0]            r_wr_ptr, r_rd_ptr, w_rd_ptr_inc;
    logic [TDATA_WIDTH-1:0] r_tx_tdata, w_cpl_tdata;
    logic [EW-1:0]          w_push_entry, w_load_entry;
    logic [7:0]             w_fmt;
    logic                   w_is_rd, w_is_wr, w_empty, w_full, w_multi;
    logic                   w_pop, w_push, w_hdr_acc, w_rx_ready, w_load;

    // Builds the completion beat for one queued read request.
    function automatic logic [TDATA_WIDTH-1:0] f_build_cpl(input logic [EW-1:0] e);
        logic [TDATA_WIDTH-1:0] t;
        logic [10:0]            len_eff;
        int                     len_i;
        t        = '0;
        len_eff  = (e[9:0] == 10'd0) ? 11'd1024 : {1'b0, e[9:0]};
        len_i    = int'(len_eff);
        t[63:48] = e[40:25];
        t[47:40] = e[24:17];
        t[70:64] = e[16:10];
        if (len_i <= MAX_CPL_DW) begin
            t[31:24]   = 8'h4A;
            t[9:0]     = e[9:0];
            t[111:109] = 3'b000;
            t[108:96]  = {len_eff, 2'b00};
            for (int i = 0; i < DATA_BITS; i++) begin
                t[256+i] = (i < 32 * len_i);
            end
        end else begin
            t[31:24]   = 8'h0A;
            t[111:109] = 3'b001;
        end
        return t;
    endfunction

    // Header decode and queue occupancy flags.
    always_comb begin
        w_fmt        = rx_tdata[31:24];
        w_is_rd      = (w_fmt == 8'h00) || (w_fmt == 8'h20);
        w_is_wr      = (w_fmt == 8'h40) || (w_fmt == 8'h60);
        w_push_entry = {rx_tdata[63:48], rx_tdata[47:40], rx_tdata[70:64], rx_tdata[9:0]};
        w_rd_ptr_inc = r_rd_ptr + {{AW{1'b0}}, 1'b1};
        w_empty      = (r_wr_ptr == r_rd_ptr);
        w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        w_multi      = !w_empty && (r_wr_ptr != w_rd_ptr_inc);
        w_pop        = (r_tx_state == TX_SEND) && tx_tready;
    end

    // RX FSM state register.
    always_ff @(posedge clk or posedge softreset) begin
        if (softreset) r_rx_state <= RX_IDLE;
        else           r_rx_state <= w_rx_state_nxt;
    end

    // RX FSM next state: a multi-beat packet is drained to its last beat.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_hdr_acc && !rx_tlast) w_rx_state_nxt = RX_DRAIN;
                else                        w_rx_state_nxt = RX_IDLE;
            end
            RX_DRAIN: begin
                if (rx_tvalid && rx_tlast) w_rx_state_nxt = RX_IDLE;
                else                       w_rx_state_nxt = RX_DRAIN;
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    // RX FSM outputs: a full queue still takes a header when it pops this cycle.
    always_comb begin
        w_rx_ready = 1'b0;
        case (r_rx_state)
            RX_IDLE:  w_rx_ready = frz_active && (!w_full || w_pop);
            RX_DRAIN: w_rx_ready = 1'b1;
            default:  w_rx_ready = 1'b0;
        endcase
        if (softreset) rx_tready = 1'b0;
        else           rx_tready = w_rx_ready;
        w_hdr_acc = (r_rx_state == RX_IDLE) && rx_tvalid && rx_tready;
        w_push    = w_hdr_acc && w_is_rd;
    end

    // Queue pointers; the extra MSB separates full from empty.
    always_ff @(posedge clk or posedge softreset) begin
        if (softreset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
        end
    end

    // Queue storage; entries are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_push_entry;
    end

    // TX FSM state register.
    always_ff @(posedge clk or posedge softreset) begin
        if (softreset) r_tx_state <= TX_IDLE;
        else           r_tx_state <= w_tx_state_nxt;
    end

    // TX FSM next state: stay in SEND across handshakes while work remains.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        case (r_tx_state)
            TX_IDLE: begin
                if (!w_empty) w_tx_state_nxt = TX_SEND;
                else          w_tx_state_nxt = TX_IDLE;
            end
            TX_SEND: begin
                if (tx_tready && !(w_multi || w_push)) w_tx_state_nxt = TX_IDLE;
                else                                   w_tx_state_nxt = TX_SEND;
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
    end

    // TX FSM outputs: choose the entry to load; forward a same-cycle push to avoid a bubble.
    always_comb begin
        w_load       = 1'b0;
        w_load_entry = r_mem[r_rd_ptr[AW-1:0]];
        case (r_tx_state)
            TX_IDLE: w_load = !w_empty;
            TX_SEND: begin
                w_load = tx_tready && (w_multi || w_push);
                if (w_multi) w_load_entry = r_mem[w_rd_ptr_inc[AW-1:0]];
                else         w_load_entry = w_push_entry;
            end
            default: w_load = 1'b0;
        endcase
        w_cpl_tdata = f_build_cpl(w_load_entry);
    end

    // Completion beat register, held until the host takes it.
    always_ff @(posedge clk or posedge softreset) begin
        if (softreset)   r_tx_tdata <= '0;
        else if (w_load) r_tx_tdata <= w_cpl_tdata;
    end

    assign tx_tvalid = (r_tx_state == TX_SEND);
    assign tx_tlast  = (r_tx_state == TX_SEND);
    assign tx_tdata  = r_tx_tdata;

`ifdef PORT_FRZ_CPL_STATS_EN
    logic [15:0] r_rd_cnt, r_wr_drop_cnt;

    // Saturating counts of completions sent and writes dropped.
    always_ff @(posedge clk or posedge softreset) begin
        if (softreset) begin
            r_rd_cnt      <= 16'd0;
            r_wr_drop_cnt <= 16'd0;
        end else begin
            if (w_pop && (r_rd_cnt != 16'hFFFF))                  r_rd_cnt      <= r_rd_cnt + 16'd1;
            if (w_hdr_acc && w_is_wr && (r_wr_drop_cnt != 16'hFFFF)) r_wr_drop_cnt <= r_wr_drop_cnt + 16'd1;
        end
    end

    assign rd_cnt      = r_rd_cnt;
    assign wr_drop_cnt = r_wr_drop_cnt;
    logic w_unused;
    assign w_unused = ^{rx_tdata[23:10], rx_tdata[39:32], rx_tdata[TDATA_WIDTH-1:71]};
`else
    assign rd_cnt      = 16'd0;
    assign wr_drop_cnt = 16'd0;
    logic w_unused;
    assign w_unused = ^{rx_tdata[23:10], rx_tdata[39:32], rx_tdata[TDATA_WIDTH-1:71], w_is_wr};
`endif
endmodule
